// File: rtl/powlib_busrrarb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding and
// a width helper used by the interface, the picker and the top.
package powlib_busrrarb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // ceil(log2(n)) with a floor of 1 so single-entry counters still get a bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/powlib_busrrarb_if.sv
// Requester-side and sink-side bus channels of the arbiter plus its debug view.
interface powlib_busrrarb_if
  import powlib_busrrarb_pkg::*;
#(
  parameter int B_WRS = 4,
  parameter int B_AW  = 2,
  parameter int B_DW  = 4,
  parameter int MAXB  = 4
) ();

  localparam int PW = clog2_min1(B_WRS);
  localparam int CW = clog2_min1(MAXB);

  // Handshake: a beat moves on a rising edge exactly when valid and ready are
  // both high; valid must not wait on ready, and payload is held while
  // valid && !ready. Dropping valid forfeits an active grant.
  logic [B_WRS*B_DW-1:0] wrdatas;
  logic [B_WRS*B_AW-1:0] wraddrs;
  logic [B_WRS-1:0]      wrvlds;
  logic [B_WRS-1:0]      wrrdys;
  logic [B_DW-1:0]       rddata;
  logic [B_AW-1:0]       rdaddr;
  logic                  rdvld;
  logic                  rdrdy;
  logic [B_WRS-1:0]      gnt;

  state_t                dbg_state;
  logic [PW-1:0]         dbg_ptr;
  logic [CW-1:0]         dbg_cnt;
  logic                  dbg_viol;

  modport master (
    output wrdatas, wraddrs, wrvlds, rdrdy,
    input  wrrdys, rddata, rdaddr, rdvld, gnt,
    input  dbg_state, dbg_ptr, dbg_cnt, dbg_viol
  );

  modport slave (
    input  wrdatas, wraddrs, wrvlds, rdrdy,
    output wrrdys, rddata, rdaddr, rdvld, gnt,
    output dbg_state, dbg_ptr, dbg_cnt, dbg_viol
  );

endinterface

// File: rtl/powlib_busrrarb_rrpick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Rotate right by ptr, priority-encode, rotate back. Assumes ptr < N.
module powlib_busrrarb_rrpick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_pick;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_pick;
  logic           found;

  always_comb begin
    dbl_req  = {req, req} >> ptr;
    rot      = dbl_req[N-1:0];
    rot_pick = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        rot_pick[i] = 1'b1;
        found       = 1'b1;
      end
    end
    dbl_pick = {rot_pick, rot_pick} << ptr;
    pick     = dbl_pick[2*N-1:N];
  end

endmodule

// File: rtl/powlib_busrrarb.sv
// Round-robin arbiter: one requester owns the output register for up to MAXB
// beats, then priority rotates to the channel after it.
module powlib_busrrarb
  import powlib_busrrarb_pkg::*;
#(
  parameter int B_WRS = 4,
  parameter int B_AW  = 2,
  parameter int B_DW  = 4,
  parameter int MAXB  = 4,
  parameter     ID    = "RRARB",
  parameter int EDBG  = 0
) (
  input  logic              clk,
  input  logic              rst,
  powlib_busrrarb_if.slave  bus
);

  localparam int PW = clog2_min1(B_WRS);
  localparam int CW = clog2_min1(MAXB);

  state_t           state;
  logic [B_WRS-1:0] gnt;
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic             rdvld;
  logic [B_DW-1:0]  rddata;
  logic [B_AW-1:0]  rdaddr;

  logic [B_WRS-1:0] pick;
  logic [B_WRS-1:0] wrrdys;
  logic [PW-1:0]    g_idx;
  logic [PW-1:0]    nxt_ptr;
  logic [B_DW-1:0]  sel_data;
  logic [B_AW-1:0]  sel_addr;
  logic             out_free;
  logic             g_vld;
  logic             beat;
  logic             last;
  logic             release_g;

  powlib_busrrarb_rrpick #(
    .N  (B_WRS),
    .PW (PW)
  ) u_pick (
    .req  (bus.wrvlds),
    .ptr  (ptr),
    .pick (pick)
  );

  // AND-OR grant mux; gnt is one-hot or zero so at most one term contributes
  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    g_idx    = '0;
    for (int i = 0; i < B_WRS; i++) begin
      sel_data = sel_data | (bus.wrdatas[i*B_DW +: B_DW] & {B_DW{gnt[i]}});
      sel_addr = sel_addr | (bus.wraddrs[i*B_AW +: B_AW] & {B_AW{gnt[i]}});
      g_idx    = g_idx | (gnt[i] ? PW'(i) : '0);
    end
  end

  always_comb begin
    out_free  = !rdvld || bus.rdrdy;
    wrrdys    = (state == HOLD && out_free) ? gnt : '0;
    g_vld     = |(bus.wrvlds & gnt);
    beat      = |(bus.wrvlds & wrrdys);
    last      = (cnt == CW'(MAXB - 1));
    release_g = (beat && last) || !g_vld;
    nxt_ptr   = (g_idx == PW'(B_WRS - 1)) ? '0 : g_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      rdvld <= 1'b0;
    end else begin
      // output register drains on its own, independent of grant release
      if (beat)                    rdvld <= 1'b1;
      else if (rdvld && bus.rdrdy) rdvld <= 1'b0;

      case (state)
        IDLE: begin
          if (|bus.wrvlds) begin
            gnt   <= pick;
            cnt   <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (release_g) begin
            gnt   <= '0;
            cnt   <= '0;
            ptr   <= nxt_ptr;
            state <= IDLE;
          end else if (beat) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // payload is a don't-care until rdvld, so it carries no reset
  always_ff @(posedge clk) begin
    if (beat) begin
      rddata <= sel_data;
      rdaddr <= sel_addr;
    end
  end

  // Optional watch for a requester changing payload while stalled
  if (EDBG != 0 && $bits(ID) > 0) begin : g_viol
    logic            stall_q;
    logic [B_DW-1:0] data_q;
    logic [B_AW-1:0] addr_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_q <= 1'b0;
      else      stall_q <= (state == HOLD) && g_vld && !out_free;
    end

    always_ff @(posedge clk) begin
      data_q <= sel_data;
      addr_q <= sel_addr;
    end

    assign bus.dbg_viol = stall_q && g_vld && (sel_data != data_q || sel_addr != addr_q);
  end else begin : g_noviol
    assign bus.dbg_viol = 1'b0;
  end

  assign bus.wrrdys    = wrrdys;
  assign bus.rddata    = rddata;
  assign bus.rdaddr    = rdaddr;
  assign bus.rdvld     = rdvld;
  assign bus.gnt       = gnt;
  assign bus.dbg_state = state;
  assign bus.dbg_ptr   = ptr;
  assign bus.dbg_cnt   = cnt;

endmodule

// File: tb/tb_powlib_busrrarb.sv
// Directed bench for powlib_busrrarb: MAXB=4 instance for most steps, MAXB=2
// instance for the rotation step; output beats are checked against a queue.
module tb_powlib_busrrarb;
  import powlib_busrrarb_pkg::*;

  localparam int W = 6;

  logic clk = 1'b0;
  logic rst;
  logic rdrdy;
  logic sel;

  always #5 clk = ~clk;

  powlib_busrrarb_if #(.B_WRS(4), .B_AW(2), .B_DW(4), .MAXB(4)) b1 ();
  powlib_busrrarb_if #(.B_WRS(4), .B_AW(2), .B_DW(4), .MAXB(2)) b2 ();

  powlib_busrrarb #(.B_WRS(4), .B_AW(2), .B_DW(4), .MAXB(4)) u_dut (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );
  powlib_busrrarb #(.B_WRS(4), .B_AW(2), .B_DW(4), .MAXB(2)) u_dut2 (
    .clk (clk), .rst (rst), .bus (b2.slave)
  );

  assign b1.rdrdy = rdrdy;
  assign b2.rdrdy = rdrdy;

  // view of whichever instance is currently active
  logic [3:0]   m_gnt;
  logic [3:0]   m_wrrdys;
  logic         m_rdvld;
  logic [W-1:0] m_out;
  logic [1:0]   m_ptr;
  logic [1:0]   m_cnt;
  state_t       m_state;

  always_comb begin
    if (sel) begin
      m_gnt = b2.gnt; m_wrrdys = b2.wrrdys; m_rdvld = b2.rdvld;
      m_out = {b2.rdaddr, b2.rddata}; m_ptr = b2.dbg_ptr;
      m_cnt = {1'b0, b2.dbg_cnt}; m_state = b2.dbg_state;
    end else begin
      m_gnt = b1.gnt; m_wrrdys = b1.wrrdys; m_rdvld = b1.rdvld;
      m_out = {b1.rdaddr, b1.rddata}; m_ptr = b1.dbg_ptr;
      m_cnt = b1.dbg_cnt; m_state = b1.dbg_state;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  int out_cyc[$];

  logic [3:0] src_d[4][32];
  int src_n[4] = '{default: 0};
  int src_rd[4] = '{default: 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [3:0] d);
    src_d[ch][src_n[ch]] = d;
    src_n[ch]++;
  endtask

  task automatic expect_beat(input int ch, input logic [3:0] d);
    exp_q.push_back({2'(ch), d});
  endtask

  task automatic wait_gnt(input logic [3:0] want, input string tag);
    int n;
    n = 0;
    while (m_gnt !== want && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(m_gnt), 32'(want));
  endtask

  task automatic wait_rdvld(input string tag);
    int n;
    n = 0;
    while (m_rdvld !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(m_rdvld), 32'h1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_gnt != 4'b0) && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'h0);
    check({tag, "_idle"}, 32'(m_gnt), 32'h0);
  endtask

  // requesters: present the head of each channel's list, pop on handshake
  initial begin : driver
    logic [3:0]  take;
    logic [3:0]  vld;
    logic [15:0] dat;
    logic [7:0]  adr;
    b1.wrvlds = '0; b1.wrdatas = '0; b1.wraddrs = '0;
    b2.wrvlds = '0; b2.wrdatas = '0; b2.wraddrs = '0;
    forever begin
      @(negedge clk);
      take = sel ? (b2.wrvlds & b2.wrrdys) : (b1.wrvlds & b1.wrrdys);
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (take[i]) src_rd[i]++;
        vld[i] = (src_rd[i] < src_n[i]);
        dat[i*4 +: 4] = 4'h0;
        if (vld[i]) dat[i*4 +: 4] = src_d[i][src_rd[i]];
        adr[i*2 +: 2] = 2'(i);
      end
      if (sel) begin
        b2.wrvlds = vld; b2.wrdatas = dat; b2.wraddrs = adr;
        b1.wrvlds = '0;  b1.wrdatas = '0;  b1.wraddrs = '0;
      end else begin
        b1.wrvlds = vld; b1.wrdatas = dat; b1.wraddrs = adr;
        b2.wrvlds = '0;  b2.wrdatas = '0;  b2.wraddrs = '0;
      end
    end
  end

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (m_rdvld && rdrdy) begin
        out_cyc.push_back(cyc);
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_beat", 32'(m_out), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst   = 1'b0;
    rdrdy = 1'b1;
    sel   = 1'b0;

    // reset held with every channel requesting
    for (int i = 0; i < 4; i++) begin
      send(i, 4'(8 + i));
      expect_beat(i, 4'(8 + i));
    end
    repeat (3) tick();
    check("rst_gnt", 32'(m_gnt), 32'h0);
    check("rst_wrrdys", 32'(m_wrrdys), 32'h0);
    check("rst_rdvld", 32'(m_rdvld), 32'h0);
    check("rst_state", 32'(m_state), 32'(IDLE));
    rst = 1'b1;
    tick();
    check("rst_first_gnt", 32'(m_gnt), 32'h1);
    drain("t1");
    check("t1_ptr_wrap", 32'(m_ptr), 32'h0);

    // early drop: ch0 one beat then low while ch3 waits
    send(0, 4'h5); send(3, 4'h6); send(3, 4'h7);
    expect_beat(0, 4'h5); expect_beat(3, 4'h6); expect_beat(3, 4'h7);
    wait_gnt(4'b0001, "t5_gnt0");
    wait_gnt(4'b0000, "t5_rel0");
    check("t5_ptr", 32'(m_ptr), 32'h1);
    check("t5_cnt", 32'(m_cnt), 32'h0);
    tick();
    check("t5_gnt3", 32'(m_gnt), 32'h8);
    drain("t5");

    // single requester, 6 beats over two grants
    out_cyc.delete();
    for (int k = 1; k <= 6; k++) begin
      send(2, 4'(k));
      expect_beat(2, 4'(k));
    end
    wait_gnt(4'b0100, "t2_gnt2");
    drain("t2");
    check("t2_nbeats", 32'(out_cyc.size()), 32'h6);
    if (out_cyc.size() == 6) begin
      for (int k = 0; k < 5; k++)
        check("t2_spacing", 32'(out_cyc[k+1] - out_cyc[k]), (k == 3) ? 32'h2 : 32'h1);
    end

    // backpressure from the sink right after the first beat
    rdrdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(1, 4'(10 + k));
      expect_beat(1, 4'(10 + k));
    end
    wait_gnt(4'b0010, "t4_gnt1");
    wait_rdvld("t4_first");
    for (int k = 0; k < 3; k++) begin
      check("t4_hold_data", 32'(m_out), 32'({2'd1, 4'd10}));
      check("t4_hold_rdy", 32'(m_wrrdys), 32'h0);
      check("t4_hold_cnt", 32'(m_cnt), 32'h1);
      check("t4_hold_gnt", 32'(m_gnt), 32'h2);
      tick();
    end
    rdrdy = 1'b1;
    drain("t4");

    // rotation with MAXB=2 on the second instance
    sel = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) send(i, 4'(k + 1));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        expect_beat(i, 4'(2*r + 1));
        expect_beat(i, 4'(2*r + 2));
      end
    wait_gnt(4'b1000, "t3_gnt3");
    wait_gnt(4'b0000, "t3_rel3");
    check("t3_ptr_wrap", 32'(m_ptr), 32'h0);
    tick();
    check("t3_regnt0", 32'(m_gnt), 32'h1);
    drain("t3");
    sel = 1'b0;
    tick();

    // asynchronous reset in the middle of a stalled burst
    rdrdy = 1'b0;
    for (int k = 0; k < 4; k++) send(2, 4'(k + 3));
    wait_gnt(4'b0100, "t6_gnt2");
    wait_rdvld("t6_inflight");
    check("t6_ptr_before", 32'(m_ptr), 32'h2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t6_gnt", 32'(m_gnt), 32'h0);
    check("t6_rdvld", 32'(m_rdvld), 32'h0);
    check("t6_wrrdys", 32'(m_wrrdys), 32'h0);
    check("t6_state", 32'(m_state), 32'(IDLE));
    check("t6_ptr", 32'(m_ptr), 32'h0);
    check("t6_cnt", 32'(m_cnt), 32'h0);
    for (int i = 0; i < 4; i++) src_rd[i] = src_n[i];
    exp_q.delete();
    rdrdy = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    send(2, 4'h7); send(0, 4'h9);
    expect_beat(0, 4'h9); expect_beat(2, 4'h7);
    wait_gnt(4'b0001, "t6_post_gnt0");
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
